// File: rtl/arbitro_bus_filtros_if.sv
// Bus between the filter units and the round-robin arbiter of the shared image-memory bus.
interface arbitro_bus_filtros_if #(
  parameter int unsigned N_SOLICITANTES = 4,
  parameter int unsigned ANCHO_INDICE   = 2
);
  logic [N_SOLICITANTES-1:0] solicitud;
  logic [N_SOLICITANTES-1:0] liberar;
  logic [N_SOLICITANTES-1:0] concesion;
  logic [ANCHO_INDICE-1:0]   indice_concesion;
  logic                      bus_ocupado;
  logic                      bus_liberado;
  logic                      expiro;

  modport master (
    output solicitud, liberar,
    input  concesion, indice_concesion, bus_ocupado, bus_liberado, expiro
  );

  modport slave (
    input  solicitud, liberar,
    output concesion, indice_concesion, bus_ocupado, bus_liberado, expiro
  );
endinterface

// File: rtl/arbitro_bus_filtros.sv
// Round-robin arbiter for the shared image-memory bus, one turnaround cycle after every release.
// Optional grant watchdog enabled by defining ARBITRO_BUS_WATCHDOG_EN.
module arbitro_bus_filtros #(
  parameter int unsigned N_SOLICITANTES = 4,
  parameter int unsigned ANCHO_INDICE   = 2,
  parameter int unsigned TIEMPO_MAX     = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  arbitro_bus_filtros_if.slave bus
);

  localparam logic [ANCHO_INDICE-1:0] ULTIMO = ANCHO_INDICE'(N_SOLICITANTES - 1);

  if (ANCHO_INDICE != $clog2(N_SOLICITANTES)) begin : g_chk_ancho
    $error("ANCHO_INDICE must equal clog2(N_SOLICITANTES)");
  end
  if (N_SOLICITANTES < 2 || N_SOLICITANTES > 8 || TIEMPO_MAX > 255) begin : g_chk_rango
    $error("N_SOLICITANTES must be 2..8 and TIEMPO_MAX must fit in 8 bits");
  end

  typedef enum logic [2:0] {
    E_LIBRE     = 3'd0,
    E_CONCEDIDO = 3'd1,
    E_LIBERANDO = 3'd2
  } estado_t;

  estado_t                   estado_q, estado_d;
  logic [N_SOLICITANTES-1:0] concesion_q, concesion_d;
  logic [ANCHO_INDICE-1:0]   indice_q, indice_d;
  logic [ANCHO_INDICE-1:0]   puntero_q, puntero_d;
  logic                      ocupado_q, ocupado_d;
  logic                      liberado_q, liberado_d;

  logic                      hay_solicitud;
  logic [ANCHO_INDICE-1:0]   seleccion;
  logic                      liberacion;
  logic                      vencido;

  // First requester at or after the priority pointer, wrapping modulo N.
  always_comb begin
    int unsigned cand;
    hay_solicitud = 1'b0;
    seleccion     = '0;
    cand          = 0;
    for (int unsigned i = 0; i < N_SOLICITANTES; i++) begin
      cand = 32'(puntero_q) + i;
      if (cand >= N_SOLICITANTES) cand = cand - N_SOLICITANTES;
      if (!hay_solicitud && bus.solicitud[ANCHO_INDICE'(cand)]) begin
        hay_solicitud = 1'b1;
        seleccion     = ANCHO_INDICE'(cand);
      end
    end
  end

  assign liberacion = bus.liberar[indice_q];

`ifdef ARBITRO_BUS_WATCHDOG_EN
  localparam logic [7:0] LIMITE = 8'(TIEMPO_MAX);

  logic [7:0] contador_q, contador_d;
  logic       expiro_q, expiro_d;

  // Counter is zero outside a grant, so it restarts on every entry to E_CONCEDIDO.
  always_comb begin
    vencido    = (contador_q == LIMITE) && !liberacion;
    contador_d = '0;
    expiro_d   = 1'b0;
    if (estado_q == E_CONCEDIDO) begin
      contador_d = contador_q + 8'd1;
      expiro_d   = vencido;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contador_q <= '0;
      expiro_q   <= 1'b0;
    end else begin
      contador_q <= contador_d;
      expiro_q   <= expiro_d;
    end
  end

  assign bus.expiro = expiro_q;
`else
  assign vencido    = 1'b0;
  assign bus.expiro = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q    <= E_LIBRE;
      concesion_q <= '0;
      indice_q    <= '0;
      puntero_q   <= '0;
      ocupado_q   <= 1'b0;
      liberado_q  <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      concesion_q <= concesion_d;
      indice_q    <= indice_d;
      puntero_q   <= puntero_d;
      ocupado_q   <= ocupado_d;
      liberado_q  <= liberado_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    concesion_d = concesion_q;
    indice_d    = indice_q;
    puntero_d   = puntero_q;
    ocupado_d   = ocupado_q;
    liberado_d  = 1'b0;
    unique case (estado_q)
      E_LIBRE: begin
        concesion_d = '0;
        ocupado_d   = 1'b0;
        if (hay_solicitud) begin
          concesion_d = N_SOLICITANTES'(1) << seleccion;
          indice_d    = seleccion;
          ocupado_d   = 1'b1;
          estado_d    = E_CONCEDIDO;
        end
      end
      E_CONCEDIDO: begin
        // A watchdog expiry ends the grant exactly like a release.
        if (liberacion || vencido) begin
          concesion_d = '0;
          ocupado_d   = 1'b0;
          liberado_d  = 1'b1;
          puntero_d   = (indice_q == ULTIMO) ? '0 : indice_q + ANCHO_INDICE'(1);
          estado_d    = E_LIBERANDO;
        end
      end
      E_LIBERANDO: begin
        estado_d = E_LIBRE;
      end
      default: begin
        estado_d    = E_LIBRE;
        concesion_d = '0;
        ocupado_d   = 1'b0;
      end
    endcase
  end

  assign bus.concesion        = concesion_q;
  assign bus.indice_concesion = indice_q;
  assign bus.bus_ocupado      = ocupado_q;
  assign bus.bus_liberado     = liberado_q;

endmodule

// File: tb/tb_arbitro_bus_filtros.sv
// Self-checking bench for arbitro_bus_filtros: directed vector table, corner sequences, random traffic vs. a reference model.
module tb_arbitro_bus_filtros;

  localparam int N    = 4;
  localparam int TMAX = 10;
`ifdef ARBITRO_BUS_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  arbitro_bus_filtros_if #(.N_SOLICITANTES(N), .ANCHO_INDICE(2)) bus ();

  arbitro_bus_filtros #(
    .N_SOLICITANTES(N),
    .ANCHO_INDICE  (2),
    .TIEMPO_MAX    (TMAX)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how long, and whether a turnaround is pending.
  int m_owner, m_idx, m_ptr, m_age;
  bit m_turn, m_lib, m_exp;

  task automatic modelo_reset();
    m_owner = -1; m_idx = 0; m_ptr = 0; m_age = 0;
    m_turn = 0; m_lib = 0; m_exp = 0;
  endtask

  task automatic modelo_paso(input logic [N-1:0] sol, input logic [N-1:0] lib);
    m_lib = 0;
    m_exp = 0;
    if (m_owner >= 0) begin
      if (lib[m_owner] || (WD && m_age == TMAX)) begin
        m_exp   = !lib[m_owner];
        m_lib   = 1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1;
      end else begin
        m_age++;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else if (sol != 0) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (m_owner < 0 && sol[c]) begin
          m_owner = c;
          m_idx   = c;
          m_age   = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nombre, input int obtenido, input int esperado);
    checks++;
    if (obtenido !== esperado) begin
      errors++;
      $display("FAIL %s: obtenido %0d esperado %0d (t=%0t)", nombre, obtenido, esperado, $time);
    end
  endtask

  task automatic comparar_modelo();
    chk("concesion",    32'(bus.concesion),        (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("indice",       32'(bus.indice_concesion), m_idx);
    chk("bus_ocupado",  32'(bus.bus_ocupado),      (m_owner >= 0) ? 1 : 0);
    chk("bus_liberado", 32'(bus.bus_liberado),     32'(m_lib));
    chk("expiro",       32'(bus.expiro),           32'(m_exp));
  endtask

  // Inputs are applied at the falling edge; outputs are checked at the next falling edge.
  task automatic tick();
    @(posedge clk);
    modelo_paso(bus.solicitud, bus.liberar);
    @(negedge clk);
    comparar_modelo();
  endtask

  typedef struct {
    logic [3:0] sol;
    logic [3:0] lib;
    logic [3:0] con;
    int         idx;
    bit         ocup;
    bit         libd;
  } vec_t;

  vec_t tabla[15];

  initial begin
    tabla[0]  = '{4'b0100, 4'b0000, 4'b0100, 2, 1, 0};
    tabla[1]  = '{4'b1111, 4'b0100, 4'b0000, 2, 0, 1};
    tabla[2]  = '{4'b1111, 4'b0000, 4'b0000, 2, 0, 0};
    tabla[3]  = '{4'b1111, 4'b0000, 4'b1000, 3, 1, 0};
    tabla[4]  = '{4'b1111, 4'b1000, 4'b0000, 3, 0, 1};
    tabla[5]  = '{4'b1111, 4'b0000, 4'b0000, 3, 0, 0};
    tabla[6]  = '{4'b1111, 4'b0000, 4'b0001, 0, 1, 0};
    tabla[7]  = '{4'b1111, 4'b0001, 4'b0000, 0, 0, 1};
    tabla[8]  = '{4'b1111, 4'b0000, 4'b0000, 0, 0, 0};
    tabla[9]  = '{4'b1111, 4'b0000, 4'b0010, 1, 1, 0};
    tabla[10] = '{4'b1111, 4'b0001, 4'b0010, 1, 1, 0};
    tabla[11] = '{4'b0000, 4'b0000, 4'b0010, 1, 1, 0};
    tabla[12] = '{4'b1111, 4'b0010, 4'b0000, 1, 0, 1};
    tabla[13] = '{4'b1111, 4'b0000, 4'b0000, 1, 0, 0};
    tabla[14] = '{4'b1111, 4'b0000, 4'b0100, 2, 1, 0};

    rst_n         = 1'b0;
    bus.solicitud = '0;
    bus.liberar   = '0;
    modelo_reset();
    repeat (2) @(negedge clk);
    comparar_modelo();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      bus.solicitud = tabla[i].sol;
      bus.liberar   = tabla[i].lib;
      @(posedge clk);
      modelo_paso(bus.solicitud, bus.liberar);
      @(negedge clk);
      chk($sformatf("tabla%0d_concesion", i), 32'(bus.concesion),        32'(tabla[i].con));
      chk($sformatf("tabla%0d_indice", i),    32'(bus.indice_concesion), tabla[i].idx);
      chk($sformatf("tabla%0d_ocupado", i),   32'(bus.bus_ocupado),      32'(tabla[i].ocup));
      chk($sformatf("tabla%0d_liberado", i),  32'(bus.bus_liberado),     32'(tabla[i].libd));
      chk($sformatf("tabla%0d_expiro", i),    32'(bus.expiro),           0);
    end

    // Owner 0 drops its request without releasing.
    bus.solicitud = 4'b0001; bus.liberar = 4'b0100; tick();
    bus.liberar = '0; tick();
    tick();
    chk("dueno0_concesion", 32'(bus.concesion), 1);
    bus.solicitud = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
`ifndef ARBITRO_BUS_WATCHDOG_EN
      chk("sin_solicitud_persiste", 32'(bus.concesion), 1);
`endif
    end
    bus.liberar = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000; tick();
    bus.liberar = '0; tick(); tick();

    // Asynchronous reset in the middle of a grant.
    bus.solicitud = 4'b1111; tick();
    chk("pre_reset_ocupado", 32'(bus.bus_ocupado), 1);
    #2 rst_n = 1'b0;
    #1;
    modelo_reset();
    chk("reset_async_concesion", 32'(bus.concesion), 0);
    chk("reset_async_ocupado",   32'(bus.bus_ocupado), 0);
    chk("reset_async_indice",    32'(bus.indice_concesion), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.solicitud = 4'b1111; tick();
    chk("post_reset_concesion", 32'(bus.concesion), 1);

    // Owner that never releases.
    bus.liberar = 4'b0001; bus.solicitud = '0; tick();
    bus.liberar = '0; tick(); tick();
    bus.solicitud = 4'b0010; tick();
    chk("wd_concesion_inicial", 32'(bus.concesion), 2);
    bus.solicitud = 4'b1111;
    for (int k = 1; k <= TMAX; k++) begin
      tick();
      chk("wd_concesion_mantenida", 32'(bus.concesion), 2);
      chk("wd_expiro_bajo", 32'(bus.expiro), 0);
    end
    tick();
`ifdef ARBITRO_BUS_WATCHDOG_EN
    chk("wd_expiro", 32'(bus.expiro), 1);
    chk("wd_liberado", 32'(bus.bus_liberado), 1);
    chk("wd_concesion_revocada", 32'(bus.concesion), 0);
    tick();
    chk("wd_giro_expiro", 32'(bus.expiro), 0);
    tick();
    chk("wd_siguiente", 32'(bus.concesion), 4);
`else
    chk("sin_wd_concesion", 32'(bus.concesion), 2);
    chk("sin_wd_expiro", 32'(bus.expiro), 0);
    repeat (10) tick();
    chk("sin_wd_persiste", 32'(bus.concesion), 2);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] l;
      l = '0;
      if (m_owner >= 0 && $urandom_range(0, 3) == 0) l = 4'(1 << m_owner);
      if ($urandom_range(0, 5) == 0) l = l | 4'($urandom_range(0, 15));
      bus.solicitud = 4'($urandom_range(0, 15));
      bus.liberar   = l;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
